// File: rtl/screen_scanout.sv
// VGA scan-out for the Hack 512x256 1-bpp screen: fetches screen RAM words, serialises
// them LSB-first and generates 640x480 timing; all VGA outputs are registered together.
module screen_scanout #(
  parameter int AW       = 13,
  parameter int DW       = 16,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int X_OFF    = 64,
  parameter int Y_OFF    = 112
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_rdata,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic          vga_de,
  output logic          vga_pixel,
  output logic          frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int WIN_W    = 512;
  localparam int SB       = $clog2(DW);
  localparam int WB       = $clog2(WIN_W / DW);
  localparam int RB       = AW - WB;
  localparam int WIN_H    = 1 << RB;
  localparam int HB       = $clog2(H_TOTAL);
  localparam int VB       = $clog2(V_TOTAL);

  logic [HB-1:0] h_cnt;
  logic [VB-1:0] v_cnt;
  logic [AW-1:0] addr_q;
  logic          load_q;
  logic [DW-1:0] shreg;

  int            h_i;
  int            v_i;
  int            hw;
  int            vw;
  int            hf;
  logic          win_h;
  logic          win_v;
  logic          issue;
  logic [AW-1:0] fetch_addr;

  // hf runs two pixels ahead of the window column so a word is fetched and loaded
  // just in time for its first pixel.
  always_comb begin
    h_i        = int'(h_cnt);
    v_i        = int'(v_cnt);
    hw         = h_i - X_OFF;
    vw         = v_i - Y_OFF;
    hf         = hw + 2;
    win_h      = (hw >= 0) && (hw < WIN_W);
    win_v      = (vw >= 0) && (vw < WIN_H);
    issue      = win_v && (hf >= 0) && (hf < WIN_W) && (hf[SB-1:0] == '0);
    fetch_addr = {vw[RB-1:0], hf[SB+WB-1:SB]};
    ram_addr   = issue ? fetch_addr : addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_i == H_TOTAL - 1) begin
      h_cnt <= '0;
      v_cnt <= (v_i == V_TOTAL - 1) ? '0 : v_cnt + VB'(1);
    end else begin
      h_cnt <= h_cnt + HB'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      load_q      <= 1'b0;
      shreg       <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_de      <= 1'b0;
      vga_pixel   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      addr_q      <= ram_addr;
      load_q      <= issue;
      // Bit 0 is the leftmost pixel; after word 31 the register drains to zero.
      shreg       <= load_q ? ram_rdata : {1'b0, shreg[DW-1:1]};
      vga_hsync   <= !((h_i >= HS_START) && (h_i < HS_END));
      vga_vsync   <= !((v_i >= VS_START) && (v_i < VS_END));
      vga_de      <= (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
      vga_pixel   <= win_h && win_v && shreg[0];
      frame_start <= (h_i == 0) && (v_i == 0);
    end
  end

endmodule
